// File: rtl/omap_biu.sv
`timescale 1ns/1ps
// Purpose: writes finished 64-bit omap buffer entries to memory as 32-bit words (high half first).
// Latency: start edge -> buffer read in cycle 1, capture in cycle 2, first write request in cycle 3.
// Backpressure: request is held stable until omap_biu2arb_rdy; no new buffer read while a word is pending.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   omap_start/omap_done        start pulse (accepted only when idle), one-cycle completion pulse
//   omap_base_addr              destination byte address, captured on an accepted start
//   omap_raddr/ren/rdata        omap buffer read port, data returned one cycle after ren
//   omap_biu2arb_req            bus ownership request, high for the whole transfer
//   omap_biu2arb_addr/data/vld/rdy   write request channel
//   arb2omap_biu_vld/rdy        write response channel, always ready
module omap_biu #(
   parameter logic [15:0] WORD_CNT    = 16'hc400,
   parameter logic [11:0] BANK_STRIDE = 12'hc40
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        omap_start,
   output logic        omap_done,
   input  logic [31:0] omap_base_addr,
   output logic [31:0] omap_raddr,
   output logic        omap_ren,
   input  logic [63:0] omap_rdata,
   output logic        omap_biu2arb_req,
   output logic [31:0] omap_biu2arb_addr,
   output logic [31:0] omap_biu2arb_data,
   output logic        omap_biu2arb_vld,
   input  logic        omap_biu2arb_rdy,
   input  logic        arb2omap_biu_vld,
   output logic        arb2omap_biu_rdy
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FETCH   = 3'd1,
      CAPT    = 3'd2,
      SEND_HI = 3'd3,
      SEND_LO = 3'd4,
      DRAIN   = 3'd5
   } state_t;

   state_t      state;
   state_t      state_d;
   logic [15:0] w;
   logic [15:0] rsp_cnt;
   logic [63:0] hold;
   logic [31:0] base;
   logic        done_q;
   logic        done_d;

   logic        hs;
   logic        last_word;
   logic        final_rsp;
   logic [2:0]  bank;
   logic [31:0] map_addr;
   logic [31:0] wr_addr;

   assign hs        = omap_biu2arb_vld & omap_biu2arb_rdy;
   assign last_word = (w == WORD_CNT - 16'd1);

   // The last response closes the transfer only once every word has been
   // accepted; it may coincide with the handshake of the final low word.
   assign final_rsp = arb2omap_biu_vld && (rsp_cnt == WORD_CNT - 16'd1) &&
                      ((state == DRAIN) || ((state == SEND_LO) && hs && last_word));

   // Same bank layout as the input-map fetch path: w[3:1] picks the bank,
   // w[15:4] the row inside it; w[0] only selects the entry half.
   assign bank     = {w[2:1], 1'b0} + {2'b00, w[3]};
   assign map_addr = {20'd0, w[15:4]} + ({29'd0, bank} * {20'd0, BANK_STRIDE});
   assign wr_addr  = base + {14'd0, w, 2'b00};

   assign omap_biu2arb_req = (state != IDLE);
   assign arb2omap_biu_rdy = 1'b1;
   assign omap_done        = done_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_d;
      end
   end

   // Request outputs decode only registered state (state, w, base, hold),
   // so they stay constant for as long as the arbiter withholds rdy.
   always_comb begin
      state_d           = state;
      done_d            = 1'b0;
      omap_ren          = 1'b0;
      omap_raddr        = 32'd0;
      omap_biu2arb_vld  = 1'b0;
      omap_biu2arb_addr = 32'd0;
      omap_biu2arb_data = 32'd0;
      case (state)
         IDLE: begin
            if (omap_start) state_d = FETCH;
         end
         FETCH: begin
            omap_ren   = 1'b1;
            omap_raddr = map_addr;
            state_d    = CAPT;
         end
         CAPT: begin
            state_d = SEND_HI;
         end
         SEND_HI: begin
            omap_biu2arb_vld  = 1'b1;
            omap_biu2arb_addr = wr_addr;
            omap_biu2arb_data = hold[63:32];
            if (hs) state_d = SEND_LO;
         end
         SEND_LO: begin
            omap_biu2arb_vld  = 1'b1;
            omap_biu2arb_addr = wr_addr;
            omap_biu2arb_data = hold[31:0];
            if (hs) begin
               if (last_word) begin
                  state_d = final_rsp ? IDLE : DRAIN;
                  done_d  = final_rsp;
               end else begin
                  state_d = FETCH;
               end
            end
         end
         DRAIN: begin
            if (final_rsp) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w       <= 16'd0;
         rsp_cnt <= 16'd0;
         hold    <= 64'd0;
         base    <= 32'd0;
         done_q  <= 1'b0;
      end else begin
         done_q <= done_d;
         case (state)
            IDLE: begin
               if (omap_start) begin
                  base    <= omap_base_addr;
                  w       <= 16'd0;
                  rsp_cnt <= 16'd0;
               end
            end
            CAPT: hold <= omap_rdata;
            SEND_HI: begin
               if (hs) w <= w + 16'd1;
            end
            SEND_LO: begin
               // w stays on the last word index once the final word is out
               if (hs && !last_word) w <= w + 16'd1;
            end
            default: ;
         endcase
         // responses may overtake the send sequence, so count in every busy state
         if ((state != IDLE) && arb2omap_biu_vld) rsp_cnt <= rsp_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_omap_biu.sv
`timescale 1ns/1ps
// Bench for omap_biu: a transaction-level model (expected word stream, fetch
// order, response count) is compared against the DUT every cycle, and directed
// scenarios add hand-computed expectations.
module tb_omap_biu;

   localparam logic [15:0] WC = 16'd16;

   logic        clk = 1'b0;
   logic        rst;

   // DUT with WORD_CNT=16
   logic        start;
   logic [31:0] base_addr;
   logic [31:0] raddr;
   logic        ren;
   logic [63:0] rdata;
   logic        req;
   logic [31:0] addr;
   logic [31:0] data;
   logic        vld;
   logic        rdy;
   logic        arb_vld;
   logic        arb_rdy;
   logic        done;

   // DUT with default parameters, used for the bank mapping
   logic        start_d;
   logic [31:0] base_d  = 32'd0;
   logic [63:0] rdata_d = 64'd0;
   logic        rdy_d   = 1'b1;
   logic        arbv_d  = 1'b0;
   logic [31:0] raddr_d;
   logic        ren_d;
   logic        req_d;
   logic [31:0] addr_d;
   logic [31:0] data_d;
   logic        vld_d;
   logic        arb_rdy_d;
   logic        done_dd;

   omap_biu #(.WORD_CNT(WC)) u_dut (
      .clk(clk), .rst(rst),
      .omap_start(start), .omap_done(done), .omap_base_addr(base_addr),
      .omap_raddr(raddr), .omap_ren(ren), .omap_rdata(rdata),
      .omap_biu2arb_req(req), .omap_biu2arb_addr(addr), .omap_biu2arb_data(data),
      .omap_biu2arb_vld(vld), .omap_biu2arb_rdy(rdy),
      .arb2omap_biu_vld(arb_vld), .arb2omap_biu_rdy(arb_rdy)
   );

   omap_biu u_dflt (
      .clk(clk), .rst(rst),
      .omap_start(start_d), .omap_done(done_dd), .omap_base_addr(base_d),
      .omap_raddr(raddr_d), .omap_ren(ren_d), .omap_rdata(rdata_d),
      .omap_biu2arb_req(req_d), .omap_biu2arb_addr(addr_d), .omap_biu2arb_data(data_d),
      .omap_biu2arb_vld(vld_d), .omap_biu2arb_rdy(rdy_d),
      .arb2omap_biu_vld(arbv_d), .arb2omap_biu_rdy(arb_rdy_d)
   );

   int n_pass = 0;
   int n_chk  = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
   endtask

   // bank = 2*w[2:1] + w[3], row = w/16
   function automatic logic [31:0] map_fn(input logic [15:0] wi);
      int unsigned wv;
      wv = wi;
      return 32'((wv / 16) + (((wv / 2) % 4) * 2 + (wv / 8) % 2) * 32'hC40);
   endfunction

   // buffer entry n lives at map(2n) and holds {A000_0000+n, B000_0000+n}
   function automatic logic [63:0] entry_at(input logic [31:0] a);
      for (int n = 0; n < 64; n++)
         if (map_fn(16'(2 * n)) == a)
            return {32'(32'hA000_0000 + n), 32'(32'hB000_0000 + n)};
      return 64'hDEAD_BEEF_0BAD_F00D;
   endfunction

   function automatic logic [31:0] exp_word(input int k);
      return (k % 2 == 0) ? 32'(32'hA000_0000 + k / 2) : 32'(32'hB000_0000 + k / 2);
   endfunction

   initial forever #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // buffer: data valid exactly one cycle after ren, junk otherwise
   initial begin
      logic        r;
      logic [31:0] a;
      rdata = 64'hDEAD_BEEF_0BAD_F00D;
      forever begin
         @(posedge clk);
         r = ren;
         a = raddr;
         #1;
         rdata = r ? entry_at(a) : 64'hDEAD_BEEF_0BAD_F00D;
      end
   end

   // write-response generator
   int   cyc = 0;
   int   pend[$];
   int   rsp_lat = 1;
   int   rsp_budget = 1000;
   bit   rsp_comb = 1'b0;
   logic arb_vld_q = 1'b0;

   assign arb_vld = rsp_comb ? (vld & rdy) : arb_vld_q;

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         if (rst) pend.delete();
         else if (vld && rdy && !rsp_comb) pend.push_back(cyc + rsp_lat - 1);
         #1;
         arb_vld_q = 1'b0;
         if (pend.size() > 0 && pend[0] <= cyc && rsp_budget > 0) begin
            void'(pend.pop_front());
            rsp_budget--;
            arb_vld_q = 1'b1;
         end
      end
   end

   // model state and per-cycle compare
   bit          m_busy = 0;
   logic [31:0] m_base = 0;
   int          m_sent = 0;
   int          m_fetched = 0;
   int          m_rsp = 0;
   bit          m_done_next = 0;
   bit          p_vld = 0, p_hs = 0, p_ren = 0;
   logic [31:0] p_addr = 0, p_data = 0;
   int          done_cnt = 0;
   int          ren_cnt = 0;
   logic [31:0] wl_addr[$];
   logic [31:0] wl_data[$];

   initial begin
      bit hs, was_busy;
      forever begin
         @(negedge clk);
         if (rst) begin
            chk("rst_req", req, 0);
            chk("rst_vld", vld, 0);
            chk("rst_ren", ren, 0);
            chk("rst_done", done, 0);
            chk("rst_raddr", raddr, 0);
            chk("rst_addr", addr, 0);
            chk("rst_data", data, 0);
            chk("rst_arb_rdy", arb_rdy, 1);
            m_busy = 0; m_sent = 0; m_fetched = 0; m_rsp = 0; m_done_next = 0;
            p_vld = 0; p_hs = 0; p_ren = 0;
         end else begin
            chk("done", done, m_done_next);
            if (done) done_cnt++;
            chk("req", req, m_busy);
            chk("arb_rdy", arb_rdy, 1);
            if (ren) begin
               ren_cnt++;
               chk("ren_back_to_back", p_ren, 0);
               chk("ren_allowed", m_busy && (m_fetched * 2 == m_sent) && (m_fetched < WC / 2), 1);
               chk("raddr", raddr, map_fn(16'(2 * m_fetched)));
            end
            if (vld) begin
               chk("vld_allowed", m_busy && (m_sent < 2 * m_fetched), 1);
               chk("wr_addr", addr, m_base + 32'(4 * m_sent));
               chk("wr_data", data, exp_word(m_sent));
            end
            if (p_vld && !p_hs) begin
               chk("vld_held", vld, 1);
               chk("addr_held", addr, p_addr);
               chk("data_held", data, p_data);
            end
            hs = vld && rdy;
            if (hs) begin
               wl_addr.push_back(addr);
               wl_data.push_back(data);
               m_sent++;
            end
            if (ren) m_fetched++;
            m_done_next = 0;
            was_busy = m_busy;
            if (was_busy && arb_vld) begin
               if (m_rsp == WC - 1 && m_sent == WC) begin
                  m_done_next = 1;
                  m_busy = 0;
               end
               m_rsp++;
            end
            if (!was_busy && start) begin
               m_busy = 1; m_base = base_addr;
               m_sent = 0; m_fetched = 0; m_rsp = 0;
            end
            p_vld = vld; p_hs = hs; p_addr = addr; p_data = data; p_ren = ren;
         end
      end
   end

   // fetch addresses of the default-parameter instance
   logic [31:0] dq[$];
   initial forever begin
      @(negedge clk);
      if (!rst && ren_d && dq.size() < 16) dq.push_back(raddr_d);
   end

   logic [31:0] exp_map [9] = '{32'h0, 32'h1880, 32'h3100, 32'h4980, 32'hC40,
                                32'h24C0, 32'h3D40, 32'h55C0, 32'h1};

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input logic [31:0] b);
      base_addr = b;
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic clear_log();
      wl_addr.delete();
      wl_data.delete();
      done_cnt = 0;
   endtask

   task automatic wait_done(input string name, input int lim);
      int k = 0;
      while (done !== 1'b1 && k < lim) begin
         tick(1);
         k++;
      end
      chk({name, "_done_seen"}, done, 1);
      chk({name, "_req_low_with_done"}, req, 0);
      tick(1);
   endtask

   initial begin
      logic [15:0] wv;
      int k;
      rst = 1'b1; start = 1'b0; base_addr = 32'd0; rdy = 1'b1; start_d = 1'b0;
      tick(3);
      #2 rst = 1'b0;
      tick(1);

      // bank mapping on the default-parameter instance
      start_d = 1'b1;
      tick(1);
      start_d = 1'b0;
      k = 0;
      while (dq.size() < 9 && k < 80) begin tick(1); k++; end
      for (int i = 0; i < 9; i++) chk($sformatf("map_w%0d", 2 * i), dq[i], exp_map[i]);
      chk("dflt_req", req_d, 1);
      chk("dflt_done", done_dd, 0);
      chk("dflt_arb_rdy", arb_rdy_d, 1);
      wv = 16'hC3FE;
      chk("map_model_last", map_fn(wv), 32'h61FF);

      // basic transfer with start latency
      clear_log();
      pulse_start(32'h1000);
      chk("lat_ren_c1", ren, 1);
      chk("lat_raddr_c1", raddr, 0);
      tick(1);
      chk("lat_ren_c2", ren, 0);
      chk("lat_vld_c2", vld, 0);
      tick(1);
      chk("lat_vld_c3", vld, 1);
      chk("lat_addr_c3", addr, 32'h1000);
      chk("lat_data_c3", data, 32'hA000_0000);
      wait_done("basic", 200);
      chk("basic_nwords", wl_addr.size(), 16);
      chk("basic_w1_data", wl_data[1], 32'hB000_0000);
      chk("basic_last_addr", wl_addr[15], 32'h103C);
      tick(3);
      chk("basic_done_pulses", done_cnt, 1);

      // backpressure in SEND_HI (5 cycles) and SEND_LO (3 cycles)
      clear_log();
      rdy = 1'b0;
      pulse_start(32'h4000);
      k = 0;
      while (vld !== 1'b1 && k < 20) begin tick(1); k++; end
      chk("bp_vld_seen", vld, 1);
      k = ren_cnt;
      tick(5);
      rdy = 1'b1;
      chk("bp_hi_addr", addr, 32'h4000);
      chk("bp_hi_data", data, 32'hA000_0000);
      tick(1);
      rdy = 1'b0;
      tick(3);
      rdy = 1'b1;
      chk("bp_lo_addr", addr, 32'h4004);
      chk("bp_lo_data", data, 32'hB000_0000);
      chk("bp_no_extra_ren", ren_cnt - k, 0);
      wait_done("bp", 200);
      chk("bp_nwords", wl_addr.size(), 16);

      // responses held back until well after the last send
      clear_log();
      rsp_budget = 0;
      pulse_start(32'h1000);
      k = 0;
      while (wl_addr.size() < 16 && k < 200) begin tick(1); k++; end
      chk("dly_all_sent", wl_addr.size(), 16);
      tick(10);
      rsp_budget = 15;
      tick(25);
      chk("dly_no_done_15", done_cnt, 0);
      chk("dly_req_still", req, 1);
      chk("dly_vld_drain", vld, 0);
      rsp_budget = 1;
      wait_done("dly", 10);
      rsp_budget = 1000;
      chk("dly_done_pulses", done_cnt, 1);

      // start while busy is ignored
      clear_log();
      pulse_start(32'h1000);
      tick(6);
      pulse_start(32'h9000);
      wait_done("busy", 200);
      chk("busy_w8_addr", wl_addr[8], 32'h1020);
      chk("busy_last_addr", wl_addr[15], 32'h103C);
      chk("busy_done_pulses", done_cnt, 1);

      // restart at new base; responses in the same cycle as the accept
      clear_log();
      rsp_comb = 1'b1;
      pulse_start(32'h2000);
      wait_done("restart", 200);
      rsp_comb = 1'b0;
      chk("restart_first_addr", wl_addr[0], 32'h2000);
      chk("restart_first_data", wl_data[0], 32'hA000_0000);
      chk("restart_nwords", wl_addr.size(), 16);

      // asynchronous reset during SEND_LO
      clear_log();
      pulse_start(32'h1000);
      k = 0;
      while (!(vld === 1'b1 && addr[2] === 1'b1) && k < 40) begin tick(1); k++; end
      chk("arst_in_send_lo", vld && addr[2], 1);
      rdy = 1'b0;
      #2 rst = 1'b1;
      pend.delete();
      #1;
      chk("arst_req", req, 0);
      chk("arst_vld", vld, 0);
      chk("arst_ren", ren, 0);
      chk("arst_done", done, 0);
      #3 rst = 1'b0;
      rdy = 1'b1;
      tick(1);
      clear_log();
      pulse_start(32'h3000);
      wait_done("post_rst", 200);
      chk("post_rst_first_addr", wl_addr[0], 32'h3000);
      chk("post_rst_nwords", wl_addr.size(), 16);

      tick(2);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
